// File: rtl/lm75a_i2c_target.sv
// LM75A-compatible I2C target: oversampled SCL/SDA, open-drain SDA, no clock stretching.
// Optional macro LM75_WREG_EN enables writes to CONF/THYST/TOS; without it data bytes are NACKed.
`timescale 1ns/1ps
module lm75a_i2c_target #(
    parameter logic [6:0]  DEV_ADDR    = 7'h48,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] TOS_RST     = 16'h5000,
    parameter logic [15:0] THYST_RST   = 16'h4B00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic [15:0] temp_data,
    output logic [7:0]  conf,
    output logic [15:0] thyst,
    output logic [15:0] tos,
    output logic        busy,
    output logic        xfer_done
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_NACK_WAIT
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic       scl_prev_q, sda_prev_q;
    logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  sr_q, sr_d;
    logic        oe_q, oe_d;
    logic [1:0]  ptr_q, ptr_d;
    logic        rw_q, rw_d;
    logic [15:0] snap_q, snap_d, snap_sel;
    logic        byte_idx_q, byte_idx_d;
    logic        mack_q, mack_d;
    logic        matched_q, matched_d;
    logic        done_q, done_d;

    assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
    assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_prev_q;
    assign scl_fall   = ~scl_s & scl_prev_q;
    assign start_det  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    // CONF is 8 bits, so duplicating it lets the byte wrap logic treat all registers alike.
    always_comb begin
        case (ptr_q)
            2'd0:    snap_sel = temp_data;
            2'd1:    snap_sel = {conf, conf};
            2'd2:    snap_sel = thyst;
            default: snap_sel = tos;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        oe_d       = oe_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        snap_d     = snap_q;
        byte_idx_d = byte_idx_q;
        mack_d     = mack_q;
        matched_d  = matched_q;
        done_d     = 1'b0;

        case (state_q)
            S_ADDR: begin
                if (scl_rise && cnt_q < 4'd8) begin
                    sr_d  = {sr_q[6:0], sda_s};
                    cnt_d = cnt_q + 4'd1;
                end else if (scl_fall && cnt_q == 4'd8) begin
                    cnt_d = 4'd0;
                    if (sr_q[7:1] == DEV_ADDR) begin
                        state_d    = S_ADDR_ACK;
                        oe_d       = 1'b1;
                        rw_d       = sr_q[0];
                        matched_d  = 1'b1;
                        snap_d     = snap_sel;
                        byte_idx_d = 1'b0;
                    end else begin
                        state_d   = S_IDLE;
                        matched_d = 1'b0;
                    end
                end
            end
            S_ADDR_ACK: begin
                if (scl_fall) begin
                    cnt_d = 4'd0;
                    if (rw_q) begin
                        state_d    = S_RDATA;
                        sr_d       = snap_q[15:8];
                        oe_d       = ~snap_q[15];
                        byte_idx_d = 1'b1;
                    end else begin
                        state_d = S_PTR;
                        oe_d    = 1'b0;
                    end
                end
            end
            S_PTR: begin
                if (scl_rise && cnt_q < 4'd8) begin
                    sr_d  = {sr_q[6:0], sda_s};
                    cnt_d = cnt_q + 4'd1;
                end else if (scl_fall && cnt_q == 4'd8) begin
                    cnt_d   = 4'd0;
                    ptr_d   = sr_q[1:0];
                    state_d = S_PTR_ACK;
                    oe_d    = 1'b1;
                end
            end
            S_PTR_ACK: begin
                if (scl_fall) begin
                    oe_d = 1'b0;
`ifdef LM75_WREG_EN
                    state_d = S_WDATA;
`else
                    state_d = S_NACK_WAIT;
`endif
                end
            end
            S_WDATA: begin
                if (scl_rise && cnt_q < 4'd8) begin
                    sr_d  = {sr_q[6:0], sda_s};
                    cnt_d = cnt_q + 4'd1;
                end else if (scl_fall && cnt_q == 4'd8) begin
                    cnt_d = 4'd0;
`ifdef LM75_WREG_EN
                    state_d = S_WDATA_ACK;
                    oe_d    = 1'b1;
`else
                    state_d = S_NACK_WAIT;
`endif
                end
            end
            S_WDATA_ACK: begin
                if (scl_fall) begin
                    oe_d    = 1'b0;
                    state_d = S_WDATA;
                end
            end
            S_RDATA: begin
                if (scl_rise && cnt_q < 4'd8) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (scl_fall && cnt_q == 4'd8) begin
                    cnt_d   = 4'd0;
                    state_d = S_RDATA_ACK;
                    oe_d    = 1'b0;
                end else if (scl_fall && cnt_q != 4'd0) begin
                    sr_d = {sr_q[6:0], 1'b0};
                    oe_d = ~sr_q[6];
                end
            end
            S_RDATA_ACK: begin
                if (scl_rise) begin
                    mack_d = sda_s;
                    cnt_d  = 4'd1;
                end else if (scl_fall && cnt_q == 4'd1) begin
                    cnt_d = 4'd0;
                    if (!mack_q) begin
                        state_d    = S_RDATA;
                        sr_d       = byte_idx_q ? snap_q[7:0] : snap_q[15:8];
                        oe_d       = byte_idx_q ? ~snap_q[7] : ~snap_q[15];
                        byte_idx_d = ~byte_idx_q;
                    end else begin
                        state_d = S_NACK_WAIT;
                        oe_d    = 1'b0;
                    end
                end
            end
            default: ;
        endcase

        // Bus conditions override whatever the byte engine decided.
        if (start_det) begin
            state_d = S_ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else if (stop_det) begin
            state_d   = S_IDLE;
            oe_d      = 1'b0;
            done_d    = matched_q;
            matched_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            sr_q       <= 8'h00;
            oe_q       <= 1'b0;
            ptr_q      <= 2'd0;
            rw_q       <= 1'b0;
            snap_q     <= 16'h0000;
            byte_idx_q <= 1'b0;
            mack_q     <= 1'b0;
            matched_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            oe_q       <= oe_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            snap_q     <= snap_d;
            byte_idx_q <= byte_idx_d;
            mack_q     <= mack_d;
            matched_q  <= matched_d;
            done_q     <= done_d;
        end
    end

    assign sda_oe    = oe_q;
    assign busy      = matched_q;
    assign xfer_done = done_q;

`ifdef LM75_WREG_EN
    logic [7:0]  conf_q, conf_d, hold_q, hold_d;
    logic [15:0] thyst_q, thyst_d, tos_q, tos_d;
    logic        wr_hi_q, wr_hi_d;
    logic        wr_strobe;

    // A byte is committed on the same clk that raises its ACK.
    assign wr_strobe = (state_q == S_WDATA) && scl_fall && (cnt_q == 4'd8);

    always_comb begin
        conf_d  = conf_q;
        thyst_d = thyst_q;
        tos_d   = tos_q;
        hold_d  = hold_q;
        wr_hi_d = wr_hi_q;
        if (start_det || stop_det) begin
            wr_hi_d = 1'b0;
        end else if (wr_strobe) begin
            case (ptr_q)
                2'd1: conf_d = sr_q;
                2'd2, 2'd3: begin
                    if (!wr_hi_q) begin
                        hold_d  = sr_q;
                        wr_hi_d = 1'b1;
                    end else begin
                        wr_hi_d = 1'b0;
                        if (ptr_q == 2'd2) thyst_d = {hold_q, sr_q[7], 7'b0};
                        else               tos_d   = {hold_q, sr_q[7], 7'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conf_q  <= 8'h00;
            thyst_q <= THYST_RST;
            tos_q   <= TOS_RST;
            hold_q  <= 8'h00;
            wr_hi_q <= 1'b0;
        end else begin
            conf_q  <= conf_d;
            thyst_q <= thyst_d;
            tos_q   <= tos_d;
            hold_q  <= hold_d;
            wr_hi_q <= wr_hi_d;
        end
    end

    assign conf  = conf_q;
    assign thyst = thyst_q;
    assign tos   = tos_q;
`else
    assign conf  = 8'h00;
    assign thyst = THYST_RST;
    assign tos   = TOS_RST;
`endif

endmodule

// File: tb/tb_lm75a_i2c_target.sv
// Directed bench for lm75a_i2c_target: a bit-banged I2C master with table-driven register reads.
`timescale 1ns/1ps
module tb_lm75a_i2c_target;

    localparam time Q = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_line;
    logic [15:0] temp_data = 16'h0000;
    logic        sda_oe, busy, xfer_done;
    logic [7:0]  conf;
    logic [15:0] thyst, tos;

    assign sda_line = sda_m & ~sda_oe;

    lm75a_i2c_target dut (
        .clk(clk), .rst_n(rst_n), .scl(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
        .temp_data(temp_data), .conf(conf), .thyst(thyst), .tos(tos),
        .busy(busy), .xfer_done(xfer_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;

    always @(negedge clk) if (xfer_done) done_cnt++;

    typedef struct {
        logic [1:0]  ptr;
        logic [15:0] temp;
        logic [7:0]  exp_msb;
        logic [7:0]  exp_lsb;
    } rd_vec_t;

    rd_vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #(2*Q);
    endtask

    task automatic wb(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
        end
        sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; ack = sda_line; #Q; scl_m = 1'b0; #Q;
    endtask

    task automatic rb(input logic ack, output logic [7:0] b);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            #Q; scl_m = 1'b1; #Q; b[i] = sda_line; #Q; scl_m = 1'b0; #Q;
        end
        sda_m = ack; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q; sda_m = 1'b1;
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic       a;
        logic [7:0] b;
        int         d0;

        vecs[0] = '{2'd0, 16'h1900, 8'h19, 8'h00};
        vecs[1] = '{2'd0, 16'hE700, 8'hE7, 8'h00};
        vecs[2] = '{2'd0, 16'hFFE0, 8'hFF, 8'hE0};
        vecs[3] = '{2'd3, 16'h1234, 8'h50, 8'h00};
        vecs[4] = '{2'd2, 16'h1234, 8'h4B, 8'h00};
        vecs[5] = '{2'd1, 16'h1234, 8'h00, 8'h00};

        #100;
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_xfer_done", xfer_done, 0);
        chk("rst_conf", conf, 8'h00);
        chk("rst_thyst", thyst, 16'h4B00);
        chk("rst_tos", tos, 16'h5000);
        #100 rst_n = 1'b1;
        #200;

        // Pointer write, repeated START, two-byte read (ACK then NACK)
        for (int v = 0; v < 6; v++) begin
            temp_data = vecs[v].temp;
            d0 = done_cnt;
            i2c_start();
            wb(8'h90, a);                    chk("vec_addr_w_ack", a, 0);
            wb({6'b0, vecs[v].ptr}, a);      chk("vec_ptr_ack", a, 0);
            chk("vec_busy", busy, 1);
            i2c_start();
            wb(8'h91, a);                    chk("vec_addr_r_ack", a, 0);
            rb(1'b0, b);                     chk("vec_msb", b, vecs[v].exp_msb);
            rb(1'b1, b);                     chk("vec_lsb", b, vecs[v].exp_lsb);
            i2c_stop();
            chk("vec_done", done_cnt - d0, 1);
            chk("vec_busy_end", busy, 0);
        end

        // Wrong address: no ACK, no busy, no done
        d0 = done_cnt;
        i2c_start();
        wb(8'h92, a);                        chk("bad_addr_nack", a, 1);
        chk("bad_addr_busy", busy, 0);
        i2c_stop();
        chk("bad_addr_done", done_cnt - d0, 0);

        // Snapshot coherence across a temp_data change mid-read
        temp_data = 16'h1900;
        i2c_start();
        wb(8'h90, a);                        chk("snap_addr_ack", a, 0);
        wb(8'h00, a);                        chk("snap_ptr_ack", a, 0);
        i2c_start();
        wb(8'h91, a);                        chk("snap_raddr_ack", a, 0);
        rb(1'b0, b);                         chk("snap_msb", b, 8'h19);
        temp_data = 16'hE700;
        rb(1'b1, b);                         chk("snap_lsb", b, 8'h00);
        i2c_stop();
        i2c_start();
        wb(8'h91, a);                        chk("snap2_addr_ack", a, 0);
        rb(1'b0, b);                         chk("snap2_msb", b, 8'hE7);
        rb(1'b1, b);                         chk("snap2_lsb", b, 8'h00);
        i2c_stop();

        // TOS write
        d0 = done_cnt;
        i2c_start();
        wb(8'h90, a);                        chk("wr_addr_ack", a, 0);
        wb(8'h03, a);                        chk("wr_ptr_ack", a, 0);
`ifdef LM75_WREG_EN
        wb(8'h55, a);                        chk("wr_d0_ack", a, 0);
        wb(8'hFF, a);                        chk("wr_d1_ack", a, 0);
        i2c_stop();
        chk("wr_tos", tos, 16'h5580);
`else
        wb(8'h55, a);                        chk("wr_d0_nack", a, 1);
        chk("wr_oe_released", sda_oe, 0);
        i2c_stop();
        chk("wr_tos", tos, 16'h5000);
`endif
        chk("wr_done", done_cnt - d0, 1);
        i2c_start();
        wb(8'h91, a);                        chk("rbk_addr_ack", a, 0);
        rb(1'b0, b);
`ifdef LM75_WREG_EN
        chk("rbk_msb", b, 8'h55);
        rb(1'b1, b);                         chk("rbk_lsb", b, 8'h80);
`else
        chk("rbk_msb", b, 8'h50);
        rb(1'b1, b);                         chk("rbk_lsb", b, 8'h00);
`endif
        i2c_stop();

        // Four ACKed reads wrap MSB/LSB; a fifth NACKed byte ends the read
        temp_data = 16'h1900;
        i2c_start();
        wb(8'h90, a);                        chk("wrap_addr_ack", a, 0);
        wb(8'h00, a);                        chk("wrap_ptr_ack", a, 0);
        i2c_start();
        wb(8'h91, a);                        chk("wrap_raddr_ack", a, 0);
        rb(1'b0, b);                         chk("wrap_b0", b, 8'h19);
        rb(1'b0, b);                         chk("wrap_b1", b, 8'h00);
        rb(1'b0, b);                         chk("wrap_b2", b, 8'h19);
        rb(1'b0, b);                         chk("wrap_b3", b, 8'h00);
        rb(1'b1, b);                         chk("wrap_b4", b, 8'h19);
        i2c_stop();

        // Reset while the target is pulling SDA low in RDATA
        i2c_start();
        wb(8'h91, a);                        chk("mrst_addr_ack", a, 0);
        chk("mrst_oe_before", sda_oe, 1);
        #30 rst_n = 1'b0;
        #20;
        chk("mrst_oe_after", sda_oe, 0);
        chk("mrst_busy_after", busy, 0);
        #50 rst_n = 1'b1;
        #100;
        d0 = done_cnt;
        i2c_start();
        wb(8'h90, a);                        chk("mrst_addr2_ack", a, 0);
        wb(8'h00, a);                        chk("mrst_ptr_ack", a, 0);
        i2c_stop();
        chk("mrst_done", done_cnt - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
